// File: rtl/bus_trace_capture.sv
// Circular bus trace for the 6502C external bus: samples {stamp, AB, DB, RW, SYNC}
// until a trigger plus a post-trigger window, then streams the window oldest-first.
module bus_trace_capture #(
    parameter int AB_W       = 16,
    parameter int DB_W       = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clock,
    input  logic                          RES_L,
    input  logic                          arm,
    input  logic                          abort,
    input  logic                          capture_en,
    input  logic [AB_W-1:0]               extAB,
    input  logic [DB_W-1:0]               extDB,
    input  logic                          RW,
    input  logic                          SYNC,
    input  logic [AB_W-1:0]               trig_addr,
    input  logic [AB_W-1:0]               trig_mask,
    input  logic [1:0]                    trig_rw,
    input  logic                          trig_sync_only,
    input  logic                          ext_trig,
    input  logic [DEPTH_LOG2-1:0]         post_count,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic [CNT_W+AB_W+DB_W+1:0]    rd_data,
    output logic [1:0]                    state,
    output logic                          triggered,
    output logic [DEPTH_LOG2:0]           fill_count,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = CNT_W + AB_W + DB_W + 2;
    localparam logic [DEPTH_LOG2:0] FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]   remaining_q, remaining_d;
    logic [DEPTH_LOG2:0]     fill_d;
    logic                    triggered_d;
    logic                    qualified;
    logic                    hit;
    logic                    wr_en_p0;
    logic                    rd_en_p0;
    logic [ENT_W-1:0]        sample_p0;
    logic [ENT_W-1:0]        mem [DEPTH];

    function automatic logic trig_match(
        input logic [AB_W-1:0] ab,
        input logic [AB_W-1:0] addr,
        input logic [AB_W-1:0] mask,
        input logic            rw,
        input logic [1:0]      rw_sel,
        input logic            sync,
        input logic            sync_only
    );
        logic rw_ok;
        case (rw_sel)
            2'b01:   rw_ok = rw;
            2'b10:   rw_ok = ~rw;
            default: rw_ok = 1'b1;
        endcase
        return ((ab & mask) == (addr & mask)) && rw_ok && (sync || !sync_only);
    endfunction

    assign state     = state_q;
    assign sample_p0 = {cycle_count, extAB, extDB, RW, SYNC};
    assign qualified = capture_en && (state_q == ST_ARMED || state_q == ST_POST);
    assign hit       = qualified && (ext_trig ||
                       trig_match(extAB, trig_addr, trig_mask, RW, trig_rw, SYNC, trig_sync_only));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        fill_d      = fill_count;
        triggered_d = triggered;
        wr_en_p0    = 1'b0;
        rd_en_p0    = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            fill_d      = '0;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d     = ST_ARMED;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        fill_d      = '0;
                        triggered_d = 1'b0;
                    end else if (state_q == ST_DONE && rd_req && fill_count != '0) begin
                        rd_en_p0 = 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        fill_d   = fill_count - 1'b1;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (qualified) begin
                        wr_en_p0 = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (fill_count != FILL_MAX)
                            fill_d = fill_count + 1'b1;
                        if (state_q == ST_ARMED) begin
                            if (hit) begin
                                triggered_d = 1'b1;
                                if (post_count == '0) begin
                                    state_d = ST_DONE;
                                end else begin
                                    state_d     = ST_POST;
                                    remaining_d = post_count;
                                end
                            end
                        end else begin
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == DEPTH_LOG2'(1))
                                state_d = ST_DONE;
                        end
                        // Oldest entry sits fill_count slots behind the write pointer.
                        if (state_d == ST_DONE)
                            rd_ptr_d = wr_ptr_d - fill_d[DEPTH_LOG2-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge RES_L) begin
        if (!RES_L) begin
            state_q     <= ST_IDLE;
            cycle_count <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            fill_count  <= '0;
            triggered   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state_q     <= state_d;
            cycle_count <= cycle_count + 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            fill_count  <= fill_d;
            triggered   <= triggered_d;
            // Read stage: one-cycle RAM latency, data held between reads.
            rd_valid    <= rd_en_p0;
            if (rd_en_p0)
                rd_data <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en_p0)
            mem[wr_ptr_q] <= sample_p0;
    end

endmodule

// File: tb/tb_bus_trace_capture.sv
// Bench for bus_trace_capture: queue-based trace model checked every cycle,
// plus directed scenarios with hand-computed readout expectations.
module tb_bus_trace_capture;

    localparam int AB_W  = 16;
    localparam int DB_W  = 8;
    localparam int DL2   = 4;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << DL2;
    localparam int ENT_W = CNT_W + AB_W + DB_W + 2;

    logic              clock;
    logic              RES_L;
    logic              arm, abort, capture_en;
    logic [AB_W-1:0]   extAB;
    logic [DB_W-1:0]   extDB;
    logic              RW, SYNC;
    logic [AB_W-1:0]   trig_addr, trig_mask;
    logic [1:0]        trig_rw;
    logic              trig_sync_only, ext_trig;
    logic [DL2-1:0]    post_count;
    logic              rd_req;
    logic              rd_valid;
    logic [ENT_W-1:0]  rd_data;
    logic [1:0]        state;
    logic              triggered;
    logic [DL2:0]      fill_count;
    logic [CNT_W-1:0]  cycle_count;

    int n_vec = 0;
    int n_err = 0;

    bus_trace_capture #(
        .AB_W(AB_W), .DB_W(DB_W), .DEPTH_LOG2(DL2), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .RES_L(RES_L), .arm(arm), .abort(abort),
        .capture_en(capture_en), .extAB(extAB), .extDB(extDB), .RW(RW), .SYNC(SYNC),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_rw(trig_rw),
        .trig_sync_only(trig_sync_only), .ext_trig(ext_trig), .post_count(post_count),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .state(state),
        .triggered(triggered), .fill_count(fill_count), .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [AB_W-1:0] f_ab(input logic [ENT_W-1:0] e);
        return e[DB_W+2 +: AB_W];
    endfunction
    function automatic logic [CNT_W-1:0] f_stamp(input logic [ENT_W-1:0] e);
        return e[AB_W+DB_W+2 +: CNT_W];
    endfunction

    // Model: the trace is a queue of at most DEPTH entries, oldest at the front.
    int               m_state = 0;
    logic             m_trig = 1'b0;
    int               m_rem = 0;
    logic [CNT_W-1:0] m_cyc = '0;
    logic             m_rd_valid = 1'b0;
    logic [ENT_W-1:0] m_rd_data = '0;
    logic [ENT_W-1:0] m_trace[$];
    logic             m_qual, m_hit, m_rwok;
    logic [ENT_W-1:0] m_ent;

    always @(posedge clock or negedge RES_L) begin
        if (!RES_L) begin
            m_state = 0; m_trig = 1'b0; m_rem = 0; m_cyc = '0;
            m_rd_valid = 1'b0; m_rd_data = '0; m_trace.delete();
        end else begin
            m_qual = capture_en && (m_state == 1 || m_state == 2);
            m_rwok = (trig_rw == 2'b01) ? RW : (trig_rw == 2'b10) ? !RW : 1'b1;
            m_hit  = m_qual && (ext_trig || (((extAB & trig_mask) == (trig_addr & trig_mask))
                     && m_rwok && (SYNC || !trig_sync_only)));
            m_ent  = {m_cyc, extAB, extDB, RW, SYNC};
            m_rd_valid = 1'b0;
            if (abort) begin
                m_state = 0; m_trace.delete(); m_trig = 1'b0;
            end else if ((m_state == 0 || m_state == 3) && arm) begin
                m_state = 1; m_trace.delete(); m_trig = 1'b0;
            end else if (m_state == 1 && m_qual) begin
                m_trace.push_back(m_ent);
                if (m_trace.size() > DEPTH) void'(m_trace.pop_front());
                if (m_hit) begin
                    m_trig = 1'b1; m_rem = int'(post_count);
                    m_state = (m_rem == 0) ? 3 : 2;
                end
            end else if (m_state == 2 && m_qual) begin
                m_trace.push_back(m_ent);
                if (m_trace.size() > DEPTH) void'(m_trace.pop_front());
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end else if (m_state == 3 && rd_req && m_trace.size() > 0) begin
                m_rd_data = m_trace.pop_front();
                m_rd_valid = 1'b1;
            end
            m_cyc = m_cyc + 1'b1;
        end
    end

    always @(negedge clock) begin
        check("state", 64'(state), 64'(m_state));
        check("triggered", 64'(triggered), 64'(m_trig));
        check("fill_count", 64'(fill_count), 64'(m_trace.size()));
        check("cycle_count", 64'(cycle_count), 64'(m_cyc));
        check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        check("rd_data", 64'(rd_data), 64'(m_rd_data));
    end

    logic [ENT_W-1:0] rd_log[$];

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic read_burst(input int n);
        rd_log.delete();
        rd_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (k == n - 1) rd_req = 1'b0;
            check("burst_rd_valid", 64'(rd_valid), 64'd1);
            rd_log.push_back(rd_data);
        end
    endtask

    task automatic run_until_done(input logic [AB_W-1:0] base, input int step_en, input int ext_at);
        int i;
        i = 0;
        while (state != 2'b11 && i < 60) begin
            extAB      = AB_W'(int'(base) + i);
            extDB      = DB_W'(i);
            capture_en = (step_en == 1) ? 1'b1 : (i % 2 == 0);
            ext_trig   = (i == ext_at);
            cyc();
            if (step_en == 2 && i == 3) begin
                check("t3_disabled_hit_trig", 64'(triggered), 64'd0);
                check("t3_disabled_hit_state", 64'(state), 64'd1);
            end
            i++;
        end
        capture_en = 1'b0;
        ext_trig   = 1'b0;
        check("reach_done", 64'(state), 64'd3);
    endtask

    initial begin
        RES_L = 1'b0; arm = 0; abort = 0; capture_en = 0; extAB = '0; extDB = '0;
        RW = 1'b1; SYNC = 0; trig_addr = '0; trig_mask = 16'hFFFF; trig_rw = 2'b00;
        trig_sync_only = 0; ext_trig = 0; post_count = '0; rd_req = 0;
        repeat (3) cyc();
        check("rst_state", 64'(state), 64'd0);
        check("rst_fill", 64'(fill_count), 64'd0);
        check("rst_cycle", 64'(cycle_count), 64'd0);
        RES_L = 1'b1;
        cyc();

        // Full wrap: 20 samples into 16 slots
        trig_addr = 16'h0200; post_count = 4'd3;
        arm = 1'b1; cyc(); arm = 1'b0;
        check("t1_armed", 64'(state), 64'd1);
        run_until_done(16'h01F0, 1, -1);
        check("t1_fill", 64'(fill_count), 64'd16);
        check("t1_trig", 64'(triggered), 64'd1);
        read_burst(16);
        for (int k = 0; k < 16; k++) begin
            check("t1_ab", 64'(f_ab(rd_log[k])), 64'(16'h01F4 + k));
            if (k > 0)
                check("t1_stamp_step", 64'(16'(f_stamp(rd_log[k]) - f_stamp(rd_log[k-1]))), 64'd1);
        end
        check("t1_fill_empty", 64'(fill_count), 64'd0);

        // Trigger on 3rd sample; arm cycle carries a matching address but is not sampled
        trig_addr = 16'h0302; post_count = 4'd2;
        capture_en = 1'b1; extAB = 16'h0302;
        arm = 1'b1; cyc(); arm = 1'b0;
        check("t2_arm_not_sampled", 64'(fill_count), 64'd0);
        check("t2_trig_cleared", 64'(triggered), 64'd0);
        run_until_done(16'h0300, 1, -1);
        check("t2_fill", 64'(fill_count), 64'd5);
        read_burst(5);
        for (int k = 0; k < 5; k++)
            check("t2_ab", 64'(f_ab(rd_log[k])), 64'(16'h0300 + k));
        rd_req = 1'b1; cyc(); rd_req = 1'b0;
        check("t2_sixth_rd", 64'(rd_valid), 64'd0);

        // capture_en every other cycle; address hit on a disabled cycle, ext_trig later
        trig_addr = 16'h0403; post_count = 4'd2;
        arm = 1'b1; cyc(); arm = 1'b0;
        run_until_done(16'h0400, 2, 8);
        check("t3_fill", 64'(fill_count), 64'd7);
        read_burst(7);
        for (int k = 0; k < 7; k++) begin
            check("t3_ab", 64'(f_ab(rd_log[k])), 64'(16'h0400 + 2 * k));
            if (k > 0)
                check("t3_stamp_step", 64'(16'(f_stamp(rd_log[k]) - f_stamp(rd_log[k-1]))), 64'd2);
        end

        // Write-only trigger, SYNC qualifier, post_count=0
        trig_addr = 16'h0500; trig_rw = 2'b10; post_count = 4'd0;
        arm = 1'b1; cyc(); arm = 1'b0;
        capture_en = 1'b1; extAB = 16'h0500; RW = 1'b1; cyc();
        check("t4_read_no_trig", 64'(triggered), 64'd0);
        RW = 1'b0; trig_sync_only = 1'b1; SYNC = 1'b0; cyc();
        check("t4_sync_no_trig", 64'(state), 64'd1);
        trig_sync_only = 1'b0; SYNC = 1'b1; cyc();
        check("t4_done_next", 64'(state), 64'd3);
        check("t4_trig", 64'(triggered), 64'd1);
        check("t4_fill", 64'(fill_count), 64'd3);
        capture_en = 1'b0; RW = 1'b1; SYNC = 1'b0;
        read_burst(3);
        check("t4_first_rw", 64'(rd_log[0][1]), 64'd1);
        check("t4_last_rw", 64'(rd_log[2][1]), 64'd0);
        check("t4_last_sync", 64'(rd_log[2][0]), 64'd1);
        check("t4_last_ab", 64'(f_ab(rd_log[2])), 64'h0500);

        // Abort vs trigger, abort in POST, arm+abort
        trig_rw = 2'b00; trig_addr = 16'h0600; post_count = 4'd5;
        arm = 1'b1; cyc(); arm = 1'b0;
        extAB = 16'h0600; capture_en = 1'b1; abort = 1'b1; cyc(); abort = 1'b0;
        check("t5_abort_beats_hit", 64'(state), 64'd0);
        check("t5_abort_trig", 64'(triggered), 64'd0);
        arm = 1'b1; cyc(); arm = 1'b0;
        cyc();
        check("t5_post", 64'(state), 64'd2);
        extAB = 16'h0601; cyc();
        abort = 1'b1; cyc(); abort = 1'b0; capture_en = 1'b0;
        check("t5_abort_idle", 64'(state), 64'd0);
        check("t5_abort_fill", 64'(fill_count), 64'd0);
        rd_req = 1'b1; cyc(); rd_req = 1'b0;
        check("t5_idle_rd", 64'(rd_valid), 64'd0);
        arm = 1'b1; abort = 1'b1; cyc(); arm = 1'b0; abort = 1'b0;
        check("t5_arm_abort", 64'(state), 64'd0);

        // Asynchronous reset in the middle of POST
        arm = 1'b1; cyc(); arm = 1'b0;
        capture_en = 1'b1; extAB = 16'h0600; cyc();
        extAB = 16'h0601; cyc();
        check("t6_in_post", 64'(state), 64'd2);
        #2 RES_L = 1'b0;
        #1;
        check("t6_rst_state", 64'(state), 64'd0);
        check("t6_rst_trig", 64'(triggered), 64'd0);
        check("t6_rst_fill", 64'(fill_count), 64'd0);
        check("t6_rst_cycle", 64'(cycle_count), 64'd0);
        check("t6_rst_rd_valid", 64'(rd_valid), 64'd0);
        check("t6_rst_rd_data", 64'(rd_data), 64'd0);
        capture_en = 1'b0;
        cyc();
        RES_L = 1'b1;
        repeat (2) cyc();
        check("t6_after_rst", 64'(state), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
